// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round controller: mole spawning, scoring and round timer
module mole_round_ctrl #(
    parameter int          GAME_S  = 60,
    parameter int          WIN1_MS = 1000,
    parameter int          WIN2_MS = 700,
    parameter int          WIN3_MS = 400,
    parameter int          GAP_MS  = 200,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_ms,
    input  logic        start,
    input  logic [1:0]  speed_lvl,
    input  logic [17:0] switches,
    output logic [17:0] leds,
    output logic [13:0] score,
    output logic [6:0]  time_left,
    output logic [1:0]  cur_speed,
    output logic        hit_pulse,
    output logic        wrong_pulse,
    output logic        miss_pulse,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_UP, S_GAP, S_OVER} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [17:0] sw_q;
    logic [4:0]  idx;
    logic [15:0] win_cnt;
    logic [15:0] gap_cnt;
    logic [9:0]  ms_cnt;

    logic [17:0] rise;
    logic [4:0]  lfsr_mod;
    logic [4:0]  spawn_idx;
    logic [1:0]  lvl_in;
    logic [15:0] win_lim;
    logic        hit;
    logic        wrong;
    logic        win_done;
    logic        sec_done;
    logic        time_up;
    logic [14:0] score_sum;

    assign busy      = (state == S_SPAWN) || (state == S_UP) || (state == S_GAP);
    assign rise      = switches & ~sw_q;
    assign lfsr_mod  = 5'(lfsr % 16'd18);
    // idx still holds the previous mole here, so consecutive moles never repeat
    assign spawn_idx = (lfsr_mod != idx) ? lfsr_mod :
                       (lfsr_mod == 5'd17) ? 5'd0 : lfsr_mod + 5'd1;
    assign lvl_in    = (speed_lvl == 2'd0) ? 2'd1 : speed_lvl;

    always_comb begin
        win_lim = 16'(WIN1_MS);
        case (cur_speed)
            2'd2:    win_lim = 16'(WIN2_MS);
            2'd3:    win_lim = 16'(WIN3_MS);
            default: win_lim = 16'(WIN1_MS);
        endcase
    end

    assign hit       = rise[idx];
    assign wrong     = !hit && ((rise & ~(18'd1 << idx)) != 18'd0);
    assign win_done  = tick_ms && (win_cnt == win_lim - 16'd1);
    assign sec_done  = busy && tick_ms && (ms_cnt == 10'd999);
    assign time_up   = sec_done && (time_left == 7'd1);
    assign score_sum = {1'b0, score} + {13'd0, cur_speed};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lfsr        <= SEED;
            sw_q        <= 18'd0;
            idx         <= 5'd0;
            win_cnt     <= 16'd0;
            gap_cnt     <= 16'd0;
            ms_cnt      <= 10'd0;
            leds        <= 18'd0;
            score       <= 14'd0;
            time_left   <= 7'(GAME_S);
            cur_speed   <= 2'd1;
            hit_pulse   <= 1'b0;
            wrong_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
        end else begin
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            sw_q        <= switches;
            hit_pulse   <= 1'b0;
            wrong_pulse <= 1'b0;
            miss_pulse  <= 1'b0;

            if (busy && tick_ms) begin
                if (sec_done) begin
                    ms_cnt    <= 10'd0;
                    time_left <= time_left - 7'd1;
                end else begin
                    ms_cnt <= ms_cnt + 10'd1;
                end
            end

            case (state)
                S_IDLE, S_OVER: begin
                    leds <= 18'd0;
                    if (start) begin
                        score     <= 14'd0;
                        time_left <= 7'(GAME_S);
                        ms_cnt    <= 10'd0;
                        state     <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    cur_speed <= lvl_in;
                    idx       <= spawn_idx;
                    leds      <= 18'd1 << spawn_idx;
                    win_cnt   <= 16'd0;
                    state     <= S_UP;
                end
                S_UP: begin
                    if (hit) begin
                        hit_pulse <= 1'b1;
                        score     <= (score_sum > 15'd9999) ? 14'd9999 : score_sum[13:0];
                        leds      <= 18'd0;
                        gap_cnt   <= 16'd0;
                        state     <= S_GAP;
                    end else if (win_done) begin
                        miss_pulse <= 1'b1;
                        leds       <= 18'd0;
                        gap_cnt    <= 16'd0;
                        state      <= S_GAP;
                    end else begin
                        if (wrong) begin
                            wrong_pulse <= 1'b1;
                            score       <= (score == 14'd0) ? 14'd0 : score - 14'd1;
                        end
                        if (tick_ms) win_cnt <= win_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    leds <= 18'd0;
                    if (tick_ms) begin
                        if (gap_cnt == 16'(GAP_MS - 1)) state <= S_SPAWN;
                        else gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Round end wins over the next state but the event above keeps its score
            if (time_up) begin
                state <= S_OVER;
                leds  <= 18'd0;
            end
        end
    end
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - directed/randomized bench for mole_round_ctrl with a reference model
module tb_mole_round_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, tick_ms, start;
    logic [1:0]  speed_lvl;
    logic [17:0] switches;
    logic [17:0] leds;
    logic [13:0] score;
    logic [6:0]  time_left;
    logic [1:0]  cur_speed;
    logic        hit_pulse, wrong_pulse, miss_pulse, busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;
    int e_score, e_idx, m_prev, e_spd;

    always #10 clk = ~clk;

    mole_round_ctrl #(.GAME_S(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .start(start),
        .speed_lvl(speed_lvl), .switches(switches), .leds(leds), .score(score),
        .time_left(time_left), .cur_speed(cur_speed), .hit_pulse(hit_pulse),
        .wrong_pulse(wrong_pulse), .miss_pulse(miss_pulse), .busy(busy)
    );

    // Reference pseudo-random sequence: taps 16,14,13,11, one step per clock
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic [17:0] sw);
        tick_ms  = t;
        switches = sw;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 18'd0);
        rst_n = 1'b1;
        m_prev  = 0;
        e_score = 0;
    endtask

    // Called while the DUT sits in its one-cycle spawn state
    task automatic spawn_expect(input string tag);
        e_idx = int'(m_lfsr) % 18;
        if (e_idx == m_prev) e_idx = (e_idx + 1) % 18;
        m_prev = e_idx;
        e_spd  = (speed_lvl == 2'd0) ? 1 : int'(speed_lvl);
        cyc(1'b0, 18'd0);
        chk({tag, "_leds"}, leds, 32'(18'd1 << e_idx));
        chk({tag, "_speed"}, cur_speed, e_spd);
    endtask

    task automatic do_start(input logic [1:0] spd);
        speed_lvl = spd;
        start = 1'b1;
        cyc(1'b0, 18'd0);
        start = 1'b0;
        chk("spawn_busy", busy, 1);
        chk("spawn_dark", leds, 0);
        spawn_expect("start");
        chk("start_time", time_left, 2);
    endtask

    task automatic do_hit(input string tag);
        cyc(1'b0, 18'd1 << e_idx);
        e_score = (e_score + e_spd > 9999) ? 9999 : e_score + e_spd;
        chk({tag, "_hit"}, hit_pulse, 1);
        chk({tag, "_score"}, score, e_score);
        chk({tag, "_dark"}, leds, 0);
        cyc(1'b0, 18'd0);
        chk({tag, "_hit_once"}, hit_pulse, 0);
    endtask

    task automatic do_wrong(input string tag);
        int w;
        w = $urandom_range(0, 16);
        if (w >= e_idx) w++;
        cyc(1'b0, 18'd1 << w);
        e_score = (e_score == 0) ? 0 : e_score - 1;
        chk({tag, "_wrong"}, wrong_pulse, 1);
        chk({tag, "_score"}, score, e_score);
        chk({tag, "_lit"}, leds, 32'(18'd1 << e_idx));
        cyc(1'b0, 18'd0);
    endtask

    task automatic do_gap(input string tag);
        for (int i = 1; i < 200; i++) cyc(1'b1, 18'd0);
        chk({tag, "_gap_dark"}, leds, 0);
        chk({tag, "_gap_busy"}, busy, 1);
        cyc(1'b1, 18'd0);
        spawn_expect(tag);
    endtask

    initial begin
        int k, old_idx, misses, not_onehot, w;
        rst_n = 1'b0; tick_ms = 1'b0; start = 1'b0; speed_lvl = 2'd1; switches = 18'd0;
        @(negedge clk);

        // Reset state, start at speed 2, hit, gap and respawn
        do_reset();
        chk("rst_leds", leds, 0);
        chk("rst_score", score, 0);
        chk("rst_time", time_left, 2);
        chk("rst_speed", cur_speed, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {hit_pulse, wrong_pulse, miss_pulse}, 0);
        do_start(2'd2);
        chk("a_busy", busy, 1);
        k = $urandom_range(0, 50);
        for (int i = 0; i < k; i++) cyc(1'b1, 18'd0);
        do_hit("a");
        old_idx = e_idx;
        do_gap("a");
        chk("a_new_idx", (e_idx != old_idx) && (leds != (18'd1 << old_idx)), 1);

        // Wrong at zero, scoring across speed changes, wrong at five
        do_reset();
        do_start(2'd3);
        do_wrong("b0");
        do_hit("b1");
        speed_lvl = 2'd2;
        do_gap("b2");
        speed_lvl = 2'd1;
        cyc(1'b0, 18'd0);
        chk("b_speed_held", cur_speed, 2);
        do_hit("b3");
        speed_lvl = 2'd0;
        do_gap("b4");
        do_wrong("b5");
        chk("b_score4", score, 4);

        // Reset coinciding with a correct rise
        rst_n = 1'b0;
        cyc(1'b0, 18'd1 << e_idx);
        rst_n = 1'b1;
        m_prev = 0; e_score = 0;
        chk("rst_hit_strobe", hit_pulse, 0);
        chk("rst_hit_score", score, 0);
        chk("rst_hit_leds", leds, 0);
        cyc(1'b0, 18'd0);

        // Window expiry at speed 3
        do_start(2'd3);
        misses = 0;
        for (int i = 1; i < 400; i++) begin
            cyc(1'b1, 18'd0);
            misses += int'(miss_pulse);
        end
        chk("c_no_early_miss", misses, 0);
        cyc(1'b1, 18'd0);
        chk("c_miss", miss_pulse, 1);
        chk("c_score", score, 0);
        chk("c_dark", leds, 0);

        // Correct and wrong rises together with window expiry at speed 2
        do_reset();
        do_start(2'd2);
        for (int i = 1; i < 700; i++) cyc(1'b1, 18'd0);
        chk("d_pre_miss", miss_pulse, 0);
        w = $urandom_range(0, 16);
        if (w >= e_idx) w++;
        cyc(1'b1, (18'd1 << e_idx) | (18'd1 << w));
        chk("d_hit", hit_pulse, 1);
        chk("d_strobes", {wrong_pulse, miss_pulse}, 0);
        chk("d_score", score, 2);

        // Full two-second round, game over, restart
        do_reset();
        do_start(2'($urandom_range(1, 3)));
        do_hit("e");
        not_onehot = 0;
        for (int t = 1; t <= 2000; t++) begin
            cyc(1'b1, 18'd0);
            if (!$onehot0(leds)) not_onehot++;
            if (t == 999)  chk("e_t999", time_left, 2);
            if (t == 1000) chk("e_t1000", time_left, 1);
            if (t == 1999) chk("e_t1999", time_left, 1);
        end
        chk("e_onehot", not_onehot, 0);
        chk("e_time0", time_left, 0);
        chk("e_over_leds", leds, 0);
        chk("e_over_busy", busy, 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 18'd0);
        chk("e_hold_score", score, e_score);
        chk("e_hold_time", time_left, 0);
        start = 1'b1;
        cyc(1'b0, 18'd0);
        start = 1'b0;
        chk("e_restart_score", score, 0);
        chk("e_restart_time", time_left, 2);
        chk("e_restart_busy", busy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mole_round_ctrl.md
MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 Parameter GAME_S, default 60, round length in seconds (1..99).
REQ-002 Parameter WIN1_MS / WIN2_MS / WIN3_MS, defaults 1000 / 700 / 400, mole-up window per speed level.
REQ-003 Parameter GAP_MS, default 200, all-LEDs-off interval between moles.
REQ-004 Parameter SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 tick_ms  input  1  one-cycle enable pulse every 1 ms; all timing counts these pulses only.
REQ-008 start  input  1  one-cycle request to begin a round.
REQ-009 speed_lvl  input  2  requested speed level 1..3; value 0 treated as 1.
REQ-010 switches  input  18  player switches, already synchronised.
REQ-011 leds  output  18  one-hot active mole, or all zero.
REQ-012 score  output  14  binary score, 0..9999.
REQ-013 time_left  output  7  seconds remaining, binary.
REQ-014 cur_speed  output  2  speed level latched for the current mole.
REQ-015 hit_pulse / wrong_pulse / miss_pulse  output  1 each  one-cycle event strobes.
REQ-016 busy  output  1  high in SPAWN, UP, GAP.

Function
REQ-017 States: IDLE, SPAWN, UP, GAP, OVER; IDLE and OVER drive leds = 0.
REQ-018 IDLE/OVER + start: score <= 0, time_left <= GAME_S, sec counter <= 0, next state SPAWN; start ignored while busy.
REQ-019 SPAWN lasts exactly one cycle: latch cur_speed from speed_lvl, idx = LFSR[15:0] mod 18; if idx equals previous mole index, use (idx+1) mod 18; next UP.
REQ-020 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock in all states except reset.
REQ-021 UP: leds = 1 << idx starting the cycle after SPAWN; window counter clears on entry and increments on tick_ms.
REQ-022 Edge detect: rise = switches & ~sw_q, sw_q registered every cycle; levels held high never re-trigger.
REQ-023 UP and rise[idx]: hit_pulse, score += cur_speed (saturate 9999), next GAP.
REQ-024 UP and rise has any bit other than idx and not rise[idx]: wrong_pulse, score -= 1 (saturate 0), stay UP, window continues.
REQ-025 UP and window count reaches WINn_MS for cur_speed with no hit that cycle: miss_pulse, score unchanged, next GAP.
REQ-026 Simultaneous in one cycle: correct edge beats wrong edges and window expiry; only one strobe per cycle.
REQ-027 GAP: leds = 0, rises ignored, after GAP_MS ticks next SPAWN.
REQ-028 Round timer: in busy states, ms counter counts tick_ms; at 1000 it clears and time_left decrements.
REQ-029 time_left reaching 0: next state OVER, leds = 0 next cycle; an event resolving in the same cycle is scored first.
REQ-030 speed_lvl changes take effect only at the next SPAWN.
REQ-031 score and time_left hold in OVER until next start.

Reset
REQ-032 rst_n low at a clock edge: state IDLE, leds 0, score 0, time_left GAME_S, cur_speed 1, all strobes 0, counters 0, LFSR SEED, sw_q 0, previous index 0.
REQ-033 Reset mid-round overrides every event in that cycle; no strobe is emitted.

Verification
REQ-034 Reset then start, speed_lvl 2 -> SPAWN one cycle, leds one-hot, cur_speed 2, time_left 60, busy 1.
REQ-035 Rise on switches[idx] during UP -> hit_pulse one cycle, score 0->2, leds 0 for 200 ticks, then new one-hot mole at a different index.
REQ-036 Rise on a non-mole switch at score 0, then at score 5 -> score stays 0, then 4; wrong_pulse each time; mole stays lit.
REQ-037 No input, speed 3 -> miss_pulse exactly 400 ticks after UP entry; score unchanged.
REQ-038 Correct and wrong rises in same cycle as window expiry -> hit_pulse only, score += cur_speed.
REQ-039 GAME_S = 2, continuous play -> time_left 2,1,0 at 1000-tick steps; OVER, leds 0, busy 0; start restarts with score 0.
